load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 23 ++
 rtl/load_store_unit_sat_counter.sv | 31 +++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit.
//   - FSM state encoding (IDLE, SETUP, ACCESS, HOLD, RESP)
//   - default implemented word-address width of the attached memory
//   - request address legality helper
package load_store_unit_pkg;

  localparam int DEF_MEM_AW = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  // A byte address is illegal when it is not word aligned, or when it
  // reaches past the words the memory implements.
  function automatic logic addr_is_bad(input logic [31:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/load_store_unit_sat_counter.sv
// Saturating up-counter used for the load/store unit status counters.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset, clears count
//   inc    - add one on the next edge (ignored once all ones)
//   count  - current value, width bits
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_r;

  // Count register: increments on inc, sticks at the maximum value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {width{1'b0}};
    end else if (inc && (count_r != {width{1'b1}})) begin
      count_r <= count_r + {{(width-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one word load or store at a time, runs it through
// a fixed SETUP/ACCESS/HOLD sequence against a simple synchronous-write,
// combinational-read memory, and returns a one-cycle response.
// Ports:
//   clock, reset                 - clock and asynchronous active-low reset
//   req_valid/req_ready          - request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata - store flag, byte address, store data
//   resp_valid/resp_rdata/resp_error - one-cycle completion, load data, reject
//   mem_ren/mem_wen/mem_addr/mem_din/mem_dout - memory port (word address)
//   rd_count/wr_count/err_count  - saturating completion counters
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_AW = DEF_MEM_AW,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_error,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] err_count
);

  lsu_state_e  state_r;
  lsu_state_e  next_state_s;
  logic        accept_s;
  logic        bad_addr_s;
  logic        write_r;
  logic        err_r;
  logic        mem_ren_r;
  logic        mem_wen_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_din_r;
  logic        resp_valid_r;
  logic        resp_error_r;
  logic [31:0] resp_rdata_r;
  logic        inc_rd_s;
  logic        inc_wr_s;
  logic        inc_err_s;

  assign accept_s   = req_valid && (state_r == IDLE);
  assign bad_addr_s = addr_is_bad(req_addr, MEM_AW);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; illegal requests skip straight to the response.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = bad_addr_s ? RESP : SETUP;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP:   next_state_s = ACCESS;
      ACCESS:  next_state_s = HOLD;
      HOLD:    next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request latch, memory port and response registers. Enables and
  // resp_valid are decoded from the next state so they come straight from
  // flops. mem_addr/mem_din only change at acceptance of a legal request,
  // so they are stable across the whole access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_r      <= 1'b0;
      err_r        <= 1'b0;
      mem_ren_r    <= 1'b0;
      mem_wen_r    <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_din_r    <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else begin
      mem_ren_r    <= (next_state_s == ACCESS) && !write_r;
      mem_wen_r    <= (next_state_s == ACCESS) && write_r;
      resp_valid_r <= (next_state_s == RESP);
      resp_error_r <= (next_state_s == RESP) && (accept_s ? bad_addr_s : err_r);
      if (accept_s) begin
        write_r      <= req_write;
        err_r        <= bad_addr_s;
        resp_rdata_r <= 32'd0;
        if (!bad_addr_s) begin
          mem_addr_r <= req_addr >> 2'd2;
          mem_din_r  <= req_wdata;
        end else begin
          mem_addr_r <= mem_addr_r;
          mem_din_r  <= mem_din_r;
        end
      end else if ((state_r == ACCESS) && !write_r) begin
        // Memory read data is only valid while mem_ren is high.
        resp_rdata_r <= mem_dout;
      end else begin
        resp_rdata_r <= resp_rdata_r;
      end
    end
  end

  // Counters update on the edge leaving RESP, so an aborted access never counts.
  assign inc_rd_s  = (state_r == RESP) && !err_r && !write_r;
  assign inc_wr_s  = (state_r == RESP) && !err_r && write_r;
  assign inc_err_s = (state_r == RESP) && err_r;

  sat_counter #(.width(CNT_W)) u_rd_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (inc_rd_s),
    .count (rd_count)
  );

  sat_counter #(.width(CNT_W)) u_wr_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (inc_wr_s),
    .count (wr_count)
  );

  sat_counter #(.width(CNT_W)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (inc_err_s),
    .count (err_count)
  );

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_error = resp_error_r;
  assign mem_ren    = mem_ren_r;
  assign mem_wen    = mem_wen_r;
  assign mem_addr   = mem_addr_r;
  assign mem_din    = mem_din_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. A second instance with CNT_W=2 shares
// the request inputs but is held in reset until the saturation scenario.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reset2 = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_error, mem_ren, mem_wen;
  logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
  logic [15:0] rd_count, wr_count, err_count;
  logic        req_ready2, resp_valid2, resp_error2, mem_ren2, mem_wen2;
  logic [31:0] resp_rdata2, mem_addr2, mem_din2, mem_dout2;
  logic [1:0]  rd_count2, wr_count2, err_count2;

  logic [31:0] mem [0:4095];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  load_store_unit #(.MEM_AW(12), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
  );

  load_store_unit #(.MEM_AW(12), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset2), .req_valid(req_valid), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_error(resp_error2),
    .mem_ren(mem_ren2), .mem_wen(mem_wen2), .mem_addr(mem_addr2), .mem_din(mem_din2),
    .mem_dout(mem_dout2), .rd_count(rd_count2), .wr_count(wr_count2), .err_count(err_count2)
  );

  // Memory model: synchronous write, combinational read.
  always @(posedge clock) begin
    if (mem_wen) mem[mem_addr[11:0]] <= mem_din;
  end
  assign mem_dout  = mem[mem_addr[11:0]];
  assign mem_dout2 = mem[mem_addr2[11:0]];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one request and observes the main instance until resp_valid.
  // cyc = cycles after the accepting edge at which resp_valid was seen (-1 on timeout).
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output int cyc, output logic [31:0] rdata, output logic err,
                        output int rens, output int wens, output int ovl,
                        output logic [31:0] addr_seen);
    cyc = -1; rdata = 32'hxxxxxxxx; err = 1'bx; rens = 0; wens = 0; ovl = 0;
    addr_seen = 32'hxxxxxxxx;
    for (int w = 0; w < 10 && !req_ready; w++) tick();
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    for (int c = 1; c <= 20; c++) begin
      if (mem_ren) rens++;
      if (mem_wen) wens++;
      if (mem_ren && mem_wen) ovl++;
      if (mem_ren || mem_wen) addr_seen = mem_addr;
      if (resp_valid) begin
        cyc = c; rdata = resp_rdata; err = resp_error;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    tests_run++;
    if (req_ready !== 1'b1 || mem_ren !== 1'b0 || mem_wen !== 1'b0 || resp_valid !== 1'b0 ||
        resp_error !== 1'b0 || resp_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_din !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b ren=%b wen=%b rv=%b re=%b rd=%h ma=%h md=%h, required 1 0 0 0 0 0 0 0",
               req_ready, mem_ren, mem_wen, resp_valid, resp_error, resp_rdata, mem_addr, mem_din);
    end
    tests_run++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0 || err_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: %0d %0d %0d, required 0 0 0", rd_count, wr_count, err_count);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_store_load();
    int cyc, rens, wens, ovl; logic [31:0] rdata, as; logic err;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, cyc, rdata, err, rens, wens, ovl, as);
    tests_run++;
    if (cyc !== 4 || wens !== 1 || rens !== 0 || as !== 32'd4 || err !== 1'b0 || rdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL store_basic: cyc=%0d wens=%0d rens=%0d addr=%h err=%b rdata=%h, required 4 1 0 4 0 0",
               cyc, wens, rens, as, err, rdata);
    end
    do_req(1'b0, 32'h10, 32'h0, cyc, rdata, err, rens, wens, ovl, as);
    tests_run++;
    if (cyc !== 4 || rens !== 1 || wens !== 0 || as !== 32'd4 || err !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL load_basic: cyc=%0d rens=%0d wens=%0d addr=%h err=%b rdata=%h, required 4 1 0 4 0 deadbeef",
               cyc, rens, wens, as, err, rdata);
    end
    tick();
    tests_run++;
    if (rd_count !== 16'd1 || wr_count !== 16'd1 || err_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL store_load_counts: rd=%0d wr=%0d err=%0d, required 1 1 0", rd_count, wr_count, err_count);
    end
  endtask

  task automatic test_error();
    int cyc, rens, wens, ovl; logic [31:0] rdata, as; logic err;
    do_req(1'b0, 32'h3, 32'h0, cyc, rdata, err, rens, wens, ovl, as);
    tests_run++;
    if (cyc !== 1 || err !== 1'b1 || rdata !== 32'd0 || rens !== 0 || wens !== 0) begin
      tests_failed++;
      $display("FAIL misaligned: cyc=%0d err=%b rdata=%h rens=%0d wens=%0d, required 1 1 0 0 0",
               cyc, err, rdata, rens, wens);
    end
    tick();
    tests_run++;
    if (err_count !== 16'd1 || rd_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL misaligned_counts: err=%0d rd=%0d, required 1 1", err_count, rd_count);
    end
  endtask

  task automatic test_boundary();
    int cyc, rens, wens, ovl; logic [31:0] rdata, as; logic err;
    do_req(1'b0, 32'h4000, 32'h0, cyc, rdata, err, rens, wens, ovl, as);
    tests_run++;
    if (cyc !== 1 || err !== 1'b1 || rens !== 0 || wens !== 0) begin
      tests_failed++;
      $display("FAIL out_of_range: cyc=%0d err=%b rens=%0d wens=%0d, required 1 1 0 0", cyc, err, rens, wens);
    end
    do_req(1'b1, 32'h3FFC, 32'h12345678, cyc, rdata, err, rens, wens, ovl, as);
    tests_run++;
    if (cyc !== 4 || err !== 1'b0 || as !== 32'h0000_0FFF || wens !== 1) begin
      tests_failed++;
      $display("FAIL top_word_store: cyc=%0d err=%b addr=%h wens=%0d, required 4 0 fff 1", cyc, err, as, wens);
    end
    do_req(1'b0, 32'h3FFC, 32'h0, cyc, rdata, err, rens, wens, ovl, as);
    tests_run++;
    if (cyc !== 4 || err !== 1'b0 || rdata !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL top_word_load: cyc=%0d err=%b rdata=%h, required 4 0 12345678", cyc, err, rdata);
    end
    tick();
    tests_run++;
    if (err_count !== 16'd2 || wr_count !== 16'd2 || rd_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL boundary_counts: err=%0d wr=%0d rd=%0d, required 2 2 2", err_count, wr_count, rd_count);
    end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int n = 0, pulses = 0, ovl = 0, wens = 0;
    logic drop = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hA5A5_0001;
    for (int c = 0; c < 40; c++) begin
      if (drop) req_valid = 1'b0;
      if (req_ready && req_valid) begin
        if (n < 3) acc[n] = c;
        n++;
        if (n == 3) drop = 1'b1;
      end
      if (resp_valid) pulses++;
      if (mem_ren && mem_wen) ovl++;
      if (mem_wen) wens++;
      tick();
    end
    req_valid = 1'b0;
    tests_run++;
    if (n !== 3 || acc[1] - acc[0] !== 5 || acc[2] - acc[1] !== 5) begin
      tests_failed++;
      $display("FAIL b2b_spacing: accepts=%0d gaps=%0d,%0d, required 3 5,5", n, acc[1] - acc[0], acc[2] - acc[1]);
    end
    tests_run++;
    if (pulses !== 3 || ovl !== 0 || wens !== 3) begin
      tests_failed++;
      $display("FAIL b2b_pulses: resp=%0d overlap=%0d wen=%0d, required 3 0 3", pulses, ovl, wens);
    end
    tests_run++;
    if (wr_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL b2b_count: wr=%0d, required 5", wr_count);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, rens, wens, ovl, rv = 0; logic [31:0] rdata, as; logic err;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h1111_2222;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 10 && !mem_wen; c++) tick();
    tests_run++;
    if (mem_wen !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_reach_access: mem_wen=%b, required 1", mem_wen);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (mem_wen !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 ||
        rd_count !== 16'd0 || wr_count !== 16'd0 || err_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL abort_async: wen=%b rv=%b ready=%b rd=%0d wr=%0d err=%0d, required 0 0 1 0 0 0",
               mem_wen, resp_valid, req_ready, rd_count, wr_count, err_count);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (resp_valid) rv++;
    end
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (resp_valid) rv++;
    end
    tests_run++;
    if (rv !== 0 || wr_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL abort_no_resp: resp=%0d wr=%0d, required 0 0", rv, wr_count);
    end
    do_req(1'b1, 32'h20, 32'hCAFEF00D, cyc, rdata, err, rens, wens, ovl, as);
    do_req(1'b0, 32'h20, 32'h0, cyc, rdata, err, rens, wens, ovl, as);
    tick();
    tests_run++;
    if (cyc !== 4 || rdata !== 32'hCAFEF00D || wr_count !== 16'd1 || rd_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL abort_recover: cyc=%0d rdata=%h wr=%0d rd=%0d, required 4 cafef00d 1 1",
               cyc, rdata, wr_count, rd_count);
    end
  endtask

  task automatic test_saturation();
    int cyc, rens, wens, ovl; logic [31:0] rdata, as; logic err;
    reset2 = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) do_req(1'b0, 32'h10, 32'h0, cyc, rdata, err, rens, wens, ovl, as);
    tick();
    tests_run++;
    if (rd_count2 !== 2'd3 || resp_rdata2 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL sat_reach: rd2=%0d rdata2=%h, required 3 deadbeef", rd_count2, resp_rdata2);
    end
    for (int k = 0; k < 2; k++) do_req(1'b0, 32'h10, 32'h0, cyc, rdata, err, rens, wens, ovl, as);
    tick();
    tests_run++;
    if (rd_count2 !== 2'd3 || rd_count !== 16'd6) begin
      tests_failed++;
      $display("FAIL sat_hold: rd2=%0d rd=%0d, required 3 6", rd_count2, rd_count);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_error();
    test_boundary();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
